// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: block sequencer for the SHA-256 compression datapath.
// Takes 512-bit blocks over valid/ready and issues IV load, working-var load,
// ROUNDS round strobes and the H accumulate, then flags the final digest.
// Optional feature: define DOUBLE_HASH_EN for a second (SHA256d) pass and the pass2_o port.
module sha256_block_ctrl #(
   parameter int unsigned ROUNDS = 64,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             msg_start_i,
   input  logic             blk_valid_i,
   input  logic             blk_last_i,
   output logic             blk_ready_o,
   output logic             w_load_o,
   output logic             h_init_o,
   output logic             wv_load_o,
   output logic             round_en_o,
   output logic [5:0]       round_idx_o,
   output logic             h_accum_o,
   output logic             digest_valid_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] block_count_o
`ifdef DOUBLE_HASH_EN
   ,
   output logic             pass2_o
`endif
);

   localparam int unsigned IDX_W = 6;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BLK,
      S_LOAD,
      S_ROUND,
      S_ACCUM,
`ifdef DOUBLE_HASH_EN
      S_DLOAD,
`endif
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic              last_q, last_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              h_init_q, h_init_d;
   logic              wv_load_q, wv_load_d;
   logic              round_en_q, round_en_d;
   logic              h_accum_q, h_accum_d;
   logic              dvalid_q, dvalid_d;
   logic              busy_q, busy_d;
`ifdef DOUBLE_HASH_EN
   logic              pass2_q, pass2_d;
`endif

   // Handshake is offered only in WAIT_BLK; a coincident msg_start takes priority.
   always_comb begin
      blk_ready_o = (state_q == S_WAIT_BLK) && !msg_start_i;
      w_load_o    = blk_ready_o && blk_valid_i;
`ifdef DOUBLE_HASH_EN
      if (state_q == S_DLOAD) w_load_o = 1'b1;
`endif
   end

   // Next-state and next-output decode; msg_start overrides every state.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      h_init_d = 1'b0;
`ifdef DOUBLE_HASH_EN
      pass2_d  = pass2_q;
`endif
      case (state_q)
         S_IDLE: ;
         S_WAIT_BLK: begin
            if (blk_valid_i) begin
               last_d  = blk_last_i;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            idx_d   = '0;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            if (idx_q == LAST_IDX) state_d = S_ACCUM;
            else                   idx_d   = idx_q + IDX_W'(1);
         end
         S_ACCUM: begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (!last_q) begin
               state_d = S_WAIT_BLK;
            end else begin
`ifdef DOUBLE_HASH_EN
               if (!pass2_q) begin
                  state_d  = S_DLOAD;
                  h_init_d = 1'b1;
                  pass2_d  = 1'b1;
                  last_d   = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef DOUBLE_HASH_EN
         S_DLOAD: state_d = S_LOAD;
`endif
         S_DONE: ;
         default: state_d = S_IDLE;
      endcase

      if (msg_start_i) begin
         state_d  = S_WAIT_BLK;
         h_init_d = 1'b1;
         cnt_d    = '0;
         idx_d    = '0;
         last_d   = 1'b0;
`ifdef DOUBLE_HASH_EN
         pass2_d  = 1'b0;
`endif
      end

      wv_load_d  = (state_d == S_LOAD);
      round_en_d = (state_d == S_ROUND);
      h_accum_d  = (state_d == S_ACCUM);
      dvalid_d   = (state_d == S_DONE);
      busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   // State, counters and registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         last_q     <= 1'b0;
         idx_q      <= '0;
         cnt_q      <= '0;
         h_init_q   <= 1'b0;
         wv_load_q  <= 1'b0;
         round_en_q <= 1'b0;
         h_accum_q  <= 1'b0;
         dvalid_q   <= 1'b0;
         busy_q     <= 1'b0;
`ifdef DOUBLE_HASH_EN
         pass2_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         h_init_q   <= h_init_d;
         wv_load_q  <= wv_load_d;
         round_en_q <= round_en_d;
         h_accum_q  <= h_accum_d;
         dvalid_q   <= dvalid_d;
         busy_q     <= busy_d;
`ifdef DOUBLE_HASH_EN
         pass2_q    <= pass2_d;
`endif
      end
   end

   assign h_init_o       = h_init_q;
   assign wv_load_o      = wv_load_q;
   assign round_en_o     = round_en_q;
   assign round_idx_o    = idx_q;
   assign h_accum_o      = h_accum_q;
   assign digest_valid_o = dvalid_q;
   assign busy_o         = busy_q;
   assign block_count_o  = cnt_q;
`ifdef DOUBLE_HASH_EN
   assign pass2_o        = pass2_q;
`endif

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed bench for sha256_block_ctrl (default build, single pass).
module tb_sha256_block_ctrl;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             msg_start = 1'b0;
   logic             blk_valid = 1'b0;
   logic             blk_last = 1'b0;
   logic             blk_ready, w_load, h_init, wv_load, round_en;
   logic [5:0]       round_idx;
   logic             h_accum, digest_valid, busy;
   logic [CNT_W-1:0] block_count;
`ifdef DOUBLE_HASH_EN
   logic             pass2;
`endif

   int checks   = 0;
   int failures = 0;
   int n_accum, n_round;

   sha256_block_ctrl #(.ROUNDS(64), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .msg_start_i(msg_start), .blk_valid_i(blk_valid), .blk_last_i(blk_last),
      .blk_ready_o(blk_ready), .w_load_o(w_load), .h_init_o(h_init),
      .wv_load_o(wv_load), .round_en_o(round_en), .round_idx_o(round_idx),
      .h_accum_o(h_accum), .digest_valid_o(digest_valid), .busy_o(busy),
      .block_count_o(block_count)
`ifdef DOUBLE_HASH_EN
      , .pass2_o(pass2)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // h_init and h_accum must never coincide.
   always @(negedge clk) begin
      if (rst_n) chk("h_init_h_accum_excl", 32'(h_init & h_accum), 32'd0);
   end

   initial begin
      // Reset state
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(blk_ready), 0);
      chk("rst_cnt", 32'(block_count), 0);
      chk("rst_idx", 32'(round_idx), 0);
      rst_n = 1'b1;
      step();
      chk("idle_ready", 32'(blk_ready), 0);

      // Single block message, handshake at T
      msg_start = 1'b1;
      step();
      msg_start = 1'b0;
      chk("start_h_init", 32'(h_init), 1);
      chk("start_busy", 32'(busy), 1);
      blk_valid = 1'b1; blk_last = 1'b1;
      #1;
      chk("wait_ready", 32'(blk_ready), 1);
      chk("wait_w_load", 32'(w_load), 1);
      step();                                   // T+1
      blk_valid = 1'b0; blk_last = 1'b0;
      chk("t1_wv_load", 32'(wv_load), 1);
      chk("t1_h_init", 32'(h_init), 0);
      chk("t1_ready", 32'(blk_ready), 0);
      chk("t1_round_en", 32'(round_en), 0);
      for (int i = 0; i < 64; i++) begin        // T+2 .. T+65
         step();
         chk("round_en", 32'(round_en), 1);
         chk("round_idx", 32'(round_idx), 32'(i));
      end
      step();                                   // T+66
      chk("t66_h_accum", 32'(h_accum), 1);
      chk("t66_round_en", 32'(round_en), 0);
      chk("t66_dvalid", 32'(digest_valid), 0);
      step();                                   // T+67
      chk("t67_dvalid", 32'(digest_valid), 1);
      chk("t67_h_accum", 32'(h_accum), 0);
      chk("t67_cnt", 32'(block_count), 1);
      chk("t67_busy", 32'(busy), 0);
      chk("t67_idx_hold", 32'(round_idx), 63);

      // blk_valid in DONE is ignored
      blk_valid = 1'b1;
      #1;
      chk("done_ready", 32'(blk_ready), 0);
      chk("done_w_load", 32'(w_load), 0);
      step();
      chk("done_hold", 32'(digest_valid), 1);
      chk("done_no_load", 32'(wv_load), 0);
      blk_valid = 1'b0;

      // Two-block message, second block 5 cycles late
      msg_start = 1'b1;
      step();
      msg_start = 1'b0;
      chk("m2_dvalid_clr", 32'(digest_valid), 0);
      chk("m2_h_init", 32'(h_init), 1);
      chk("m2_cnt_clr", 32'(block_count), 0);
      blk_valid = 1'b1; blk_last = 1'b0;
      n_accum = 0; n_round = 0;
      step();
      blk_valid = 1'b0;
      for (int i = 0; i < 65; i++) begin
         n_accum += int'(h_accum);
         n_round += int'(round_en);
         step();
      end
      n_accum += int'(h_accum);                 // T+66
      chk("b1_rounds", 32'(n_round), 64);
      step();                                   // T+67
      chk("b1_cnt", 32'(block_count), 1);
      chk("b1_not_done", 32'(digest_valid), 0);
      for (int i = 0; i < 5; i++) begin
         chk("gap_ready", 32'(blk_ready), 1);
         chk("gap_round_en", 32'(round_en), 0);
         step();
      end
      blk_valid = 1'b1; blk_last = 1'b1;
      #1;
      chk("b2_w_load", 32'(w_load), 1);
      step();
      blk_valid = 1'b0; blk_last = 1'b0;
      for (int i = 0; i < 66; i++) begin
         n_accum += int'(h_accum);
         step();
      end
      chk("b2_accums", 32'(n_accum), 2);
      chk("b2_dvalid", 32'(digest_valid), 1);
      chk("b2_cnt", 32'(block_count), 2);

      // Abort mid-rounds at round_idx 40
      msg_start = 1'b1;
      step();
      msg_start = 1'b0;
      blk_valid = 1'b1; blk_last = 1'b1;
      step();
      blk_valid = 1'b0; blk_last = 1'b0;
      for (int i = 0; i < 41; i++) step();
      chk("ab_idx40", 32'(round_idx), 40);
      chk("ab_round_en", 32'(round_en), 1);
      msg_start = 1'b1;
      step();
      msg_start = 1'b0;
      #1;
      chk("ab_h_init", 32'(h_init), 1);
      chk("ab_round_en_off", 32'(round_en), 0);
      chk("ab_cnt", 32'(block_count), 0);
      chk("ab_idx", 32'(round_idx), 0);
      chk("ab_ready", 32'(blk_ready), 1);
      n_accum = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         n_accum += int'(h_accum);
      end
      chk("ab_no_accum", 32'(n_accum), 0);
      chk("ab_still_ready", 32'(blk_ready), 1);

      // msg_start beats a coincident handshake
      msg_start = 1'b1; blk_valid = 1'b1;
      #1;
      chk("win_w_load", 32'(w_load), 0);
      step();
      msg_start = 1'b0; blk_valid = 1'b0;
      chk("win_h_init", 32'(h_init), 1);
      step();
      chk("win_no_wv_load", 32'(wv_load), 0);

      // Async reset in the middle of rounds
      blk_valid = 1'b1; blk_last = 1'b1;
      step();
      blk_valid = 1'b0; blk_last = 1'b0;
      for (int i = 0; i < 31; i++) step();
      chk("rs_idx30", 32'(round_idx), 30);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs_round_en", 32'(round_en), 0);
      chk("rs_busy", 32'(busy), 0);
      chk("rs_idx", 32'(round_idx), 0);
      #3;
      rst_n = 1'b1;
      blk_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rs_idle_ready", 32'(blk_ready), 0);
         chk("rs_idle_w_load", 32'(w_load), 0);
      end
      blk_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
